// File: rtl/alu_share_arb_if.sv
// One client's request/response bundle toward the shared-ALU arbiter.
// master = client side, slave = arbiter side.
interface alu_share_arb_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero
    );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin share of one combinational ALU between two clients; result registered, valid one cycle after accept.
// A full, undrained response slot blocks only its own client; draining and refilling in one cycle is bubble-free.
module alu_share_arb #(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_share_arb_if.slave    req0,
    alu_share_arb_if.slave    req1,
    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    output logic [3:0]        alu_op,
    input  logic [31:0]       alu_result,
    input  logic              alu_zero,
    output logic [CNT_W-1:0]  issue_cnt_0,
    output logic [CNT_W-1:0]  issue_cnt_1
);

    logic [1:0]       req_vld;
    logic [1:0]       rsp_rdy;
    logic [31:0]      req_a   [2];
    logic [31:0]      req_b   [2];
    logic [3:0]       req_op  [2];

    logic [1:0]       free;
    logic [1:0]       elig;
    logic [1:0]       grant;

    logic             prio_q;
    logic [1:0]       rsp_vld_q;
    logic [1:0]       rsp_zero_q;
    logic [31:0]      rsp_res_q [2];
    logic [CNT_W-1:0] cnt_q     [2];

    assign req_vld   = {req1.req_valid, req0.req_valid};
    assign rsp_rdy   = {req1.rsp_ready, req0.rsp_ready};
    assign req_a[0]  = req0.req_a;
    assign req_a[1]  = req1.req_a;
    assign req_b[0]  = req0.req_b;
    assign req_b[1]  = req1.req_b;
    assign req_op[0] = req0.req_op;
    assign req_op[1] = req1.req_op;

    // A slot being drained this cycle may be refilled in the same cycle.
    assign free = ~rsp_vld_q | rsp_rdy;
    assign elig = req_vld & free;

    always_comb begin
        grant = 2'b00;
        if (elig == 2'b11) begin
            grant = prio_q ? 2'b10 : 2'b01;
        end else begin
            grant = elig;
        end
        // Reset blocks grants asynchronously so ready and ALU drive read 0 while held.
        if (!rst_n) begin
            grant = 2'b00;
        end
    end

    // Idle drive is ADD 0,0 so the shared ALU inputs stay quiet.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = '0;
        if (grant[0]) begin
            alu_a  = req_a[0];
            alu_b  = req_b[0];
            alu_op = req_op[0];
        end else if (grant[1]) begin
            alu_a  = req_a[1];
            alu_b  = req_b[1];
            alu_op = req_op[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q     <= 1'b0;
            rsp_vld_q  <= '0;
            rsp_zero_q <= '0;
            for (int i = 0; i < 2; i++) begin
                rsp_res_q[i] <= '0;
                cnt_q[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (grant[i]) begin
                    rsp_vld_q[i]  <= 1'b1;
                    rsp_res_q[i]  <= alu_result;
                    rsp_zero_q[i] <= alu_zero;
                    cnt_q[i]      <= cnt_q[i] + CNT_W'(1);
                end else if (rsp_vld_q[i] && rsp_rdy[i]) begin
                    rsp_vld_q[i]  <= 1'b0;
                end
            end
            if (grant[0]) begin
                prio_q <= 1'b1;
            end else if (grant[1]) begin
                prio_q <= 1'b0;
            end
        end
    end

    assign req0.req_ready  = grant[0];
    assign req1.req_ready  = grant[1];
    assign req0.rsp_valid  = rsp_vld_q[0];
    assign req1.rsp_valid  = rsp_vld_q[1];
    assign req0.rsp_result = rsp_res_q[0];
    assign req1.rsp_result = rsp_res_q[1];
    assign req0.rsp_zero   = rsp_zero_q[0];
    assign req1.rsp_zero   = rsp_zero_q[1];
    assign issue_cnt_0     = cnt_q[0];
    assign issue_cnt_1     = cnt_q[1];

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a behavioural ALU closing the loop.
module tb_alu_share_arb;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [3:0]       alu_op;
    logic [31:0]      alu_result;
    logic             alu_zero;
    logic [CNT_W-1:0] issue_cnt_0;
    logic [CNT_W-1:0] issue_cnt_1;

    int n_tests;
    int n_fail;

    alu_share_arb_if r0 ();
    alu_share_arb_if r1 ();

    alu_share_arb #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0       (r0.slave),
        .req1       (r1.slave),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .issue_cnt_0(issue_cnt_0),
        .issue_cnt_1(issue_cnt_1)
    );

    // Shared ALU: 0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 SLL 6 SRL 7 SRA 8 SLT 9 SLTU 10 LUI
    always_comb begin
        alu_result = alu_a;
        case (alu_op)
            4'd0:  alu_result = alu_a + alu_b;
            4'd1:  alu_result = alu_a - alu_b;
            4'd2:  alu_result = alu_a & alu_b;
            4'd3:  alu_result = alu_a | alu_b;
            4'd4:  alu_result = alu_a ^ alu_b;
            4'd5:  alu_result = alu_a << alu_b[4:0];
            4'd6:  alu_result = alu_a >> alu_b[4:0];
            4'd7:  alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            4'd8:  alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'd9:  alu_result = {31'd0, alu_a < alu_b};
            4'd10: alu_result = alu_b;
            default: alu_result = alu_a;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        r0.req_valid = v;
        r0.req_a     = a;
        r0.req_b     = b;
        r0.req_op    = op;
    endtask

    task automatic set1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        r1.req_valid = v;
        r1.req_a     = a;
        r1.req_b     = b;
        r1.req_op    = op;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        set0(1'b1, 32'd9, 32'd9, 4'd3);
        set1(1'b1, 32'd4, 32'd4, 4'd3);
        r0.rsp_ready = 1'b1;
        r1.rsp_ready = 1'b1;
        #1;
        check("rst_rdy0", {31'd0, r0.req_ready}, 32'd0);
        check("rst_rdy1", {31'd0, r1.req_ready}, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_op", {28'd0, alu_op}, 32'd0);
        cyc();
        check("rst_vld0", {31'd0, r0.rsp_valid}, 32'd0);
        check("rst_cnt0", {28'd0, issue_cnt_0}, 32'd0);
        set0(1'b0, 32'd9, 32'd9, 4'd3);
        set1(1'b0, 32'd4, 32'd4, 4'd3);
        rst_n = 1'b1;
        #1;
        check("idle_alu_a", alu_a, 32'd0);
        check("idle_alu_b", alu_b, 32'd0);

        // Single requester: SUB 5-3, then SUB 7-7
        cyc();
        set0(1'b1, 32'd5, 32'd3, 4'd1);
        #1;
        check("single_rdy0", {31'd0, r0.req_ready}, 32'd1);
        check("single_alu_a", alu_a, 32'd5);
        check("single_alu_op", {28'd0, alu_op}, 32'd1);
        cyc();
        check("sub_vld", {31'd0, r0.rsp_valid}, 32'd1);
        check("sub_res", r0.rsp_result, 32'd2);
        check("sub_zero", {31'd0, r0.rsp_zero}, 32'd0);
        set0(1'b1, 32'd7, 32'd7, 4'd1);
        r0.rsp_ready = 1'b0;
        #1;
        check("full_stall_rdy0", {31'd0, r0.req_ready}, 32'd0);
        r0.rsp_ready = 1'b1;
        cyc();
        check("sub0_res", r0.rsp_result, 32'd0);
        check("sub0_zero", {31'd0, r0.rsp_zero}, 32'd1);
        check("cnt0_two", {28'd0, issue_cnt_0}, 32'd2);
        set0(1'b0, 32'd1, 32'd1, 4'd0);
        r0.rsp_ready = 1'b0;
        cyc();
        check("hold_vld0", {31'd0, r0.rsp_valid}, 32'd1);

        // Mid-run asynchronous reset with slot 0 full
        set0(1'b1, 32'd1, 32'd1, 4'd0);
        rst_n = 1'b0;
        #1;
        check("arst_vld0", {31'd0, r0.rsp_valid}, 32'd0);
        check("arst_zero0", {31'd0, r0.rsp_zero}, 32'd0);
        check("arst_res0", r0.rsp_result, 32'd0);
        check("arst_cnt0", {28'd0, issue_cnt_0}, 32'd0);
        check("arst_rdy0", {31'd0, r0.req_ready}, 32'd0);
        check("arst_alu_a", alu_a, 32'd0);
        cyc();
        check("arst_edge_vld0", {31'd0, r0.rsp_valid}, 32'd0);
        rst_n = 1'b1;
        r0.rsp_ready = 1'b1;
        r1.rsp_ready = 1'b1;

        // Contention: ADD 1+1 vs XOR 0xFF^0x0F, requester 0 first after reset
        set0(1'b1, 32'd1, 32'd1, 4'd0);
        set1(1'b1, 32'hFF, 32'h0F, 4'd4);
        for (int k = 0; k < 8; k++) begin
            #1;
            check($sformatf("cont_rdy0_%0d", k), {31'd0, r0.req_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("cont_rdy1_%0d", k), {31'd0, r1.req_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
            cyc();
            if (k % 2 == 0) begin
                check($sformatf("cont_res0_%0d", k), r0.rsp_result, 32'd2);
                check($sformatf("cont_vld0_%0d", k), {31'd0, r0.rsp_valid}, 32'd1);
            end else begin
                check($sformatf("cont_res1_%0d", k), r1.rsp_result, 32'hF0);
                check($sformatf("cont_drain0_%0d", k), {31'd0, r0.rsp_valid}, 32'd0);
            end
        end
        check("cont_cnt0", {28'd0, issue_cnt_0}, 32'd4);
        check("cont_cnt1", {28'd0, issue_cnt_1}, 32'd4);

        // Backpressure on slot 1: requester 0 owns the ALU every cycle
        r1.rsp_ready = 1'b0;
        set1(1'b1, 32'h0F0F, 32'h00FF, 4'd4);
        for (int k = 0; k < 4; k++) begin
            set0(1'b1, k, 32'd10, 4'd0);
            #1;
            check($sformatf("bp_rdy1_%0d", k), {31'd0, r1.req_ready}, 32'd0);
            check($sformatf("bp_rdy0_%0d", k), {31'd0, r0.req_ready}, 32'd1);
            cyc();
            check($sformatf("bp_res0_%0d", k), r0.rsp_result, 32'(k + 10));
            check($sformatf("bp_vld0_%0d", k), {31'd0, r0.rsp_valid}, 32'd1);
            check($sformatf("bp_hold1_%0d", k), r1.rsp_result, 32'hF0);
        end
        r1.rsp_ready = 1'b1;
        #1;
        check("refill_rdy1", {31'd0, r1.req_ready}, 32'd1);
        check("refill_rdy0", {31'd0, r0.req_ready}, 32'd0);
        cyc();
        check("refill_res1", r1.rsp_result, 32'h0FF0);
        check("refill_vld1", {31'd0, r1.rsp_valid}, 32'd1);
        check("bp_cnt0", {28'd0, issue_cnt_0}, 32'd8);
        check("bp_cnt1", {28'd0, issue_cnt_1}, 32'd5);

        // Drain and refill slot 0 in the same cycle
        set1(1'b0, 32'd0, 32'd0, 4'd0);
        set0(1'b1, 32'd2, 32'd3, 4'd0);
        cyc();
        check("pre_res0", r0.rsp_result, 32'd5);
        set0(1'b1, 32'd1, 32'd4, 4'd5);
        #1;
        check("dr_vld0_before", {31'd0, r0.rsp_valid}, 32'd1);
        check("dr_rdy0", {31'd0, r0.req_ready}, 32'd1);
        cyc();
        check("dr_vld0_after", {31'd0, r0.rsp_valid}, 32'd1);
        check("dr_res0", r0.rsp_result, 32'd16);

        // Counter wrap at CNT_W = 4
        set0(1'b0, 32'd0, 32'd0, 4'd0);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        set0(1'b1, 32'd3, 32'd0, 4'd0);
        for (int k = 1; k <= 17; k++) begin
            cyc();
            if (k == 15) check("wrap_cnt15", {28'd0, issue_cnt_0}, 32'd15);
            if (k == 16) check("wrap_cnt16", {28'd0, issue_cnt_0}, 32'd0);
        end
        check("wrap_cnt17", {28'd0, issue_cnt_0}, 32'd1);
        check("wrap_cnt1", {28'd0, issue_cnt_1}, 32'd0);
        set0(1'b0, 32'd0, 32'd0, 4'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
